// File: rtl/sprite_blitter.sv
// sprite_blitter: reads an 8-pixel-wide sprite one row at a time from a
// synchronous ROM and emits one pixel per cycle (x, y, colour, plot) to the VGA
// stage. Each row costs 10 cycles: FETCH, LATCH and 8 DRAW cycles.
//
// Handshake: start is a single-cycle command strobe. It is sampled only in IDLE.
// While busy is high, start is ignored and nothing is queued. done pulses for
// exactly one cycle, in the last busy cycle.
module sprite_blitter #(
    parameter int ROWS        = 8,
    parameter bit TRANSPARENT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [1:0] sprite,
    output logic [4:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_o
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [RW-1:0] row_q;
    logic [2:0]    col_q;
    logic [7:0]    rowreg_q;
    logic [7:0]    x0_q;
    logic [6:0]    y0_q;
    logic [1:0]    spr_q;
    logic [4:0]    mem_addr_q;
    logic [7:0]    x_q;
    logic [6:0]    y_q;
    logic          colour_q;
    logic          plot_q;
    logic          busy_q;
    logic          done_q;

    logic          pix_d;
    logic [RW-1:0] row_d;
    logic [7:0]    x_d;

    // Row address into the ROM: sprite*ROWS + row, truncated to the 5-bit bus.
    function automatic logic [4:0] row_addr(input logic [1:0] spr, input logic [RW-1:0] r);
        logic [31:0] a;
        a = 32'(spr) * 32'(ROWS) + 32'(r);
        return a[4:0];
    endfunction

    // Next-pixel values while stepping through a row (MSB is the leftmost pixel).
    always_comb begin
        pix_d = rowreg_q[3'd6 - col_q];
        row_d = RW'(row_q + 1'b1);
        x_d   = x0_q + {5'd0, col_q} + 8'd1;
    end

    // Main control FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rowreg_q   <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            spr_q      <= '0;
            mem_addr_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= 1'b0;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x0_q       <= x0;
                        y0_q       <= y0;
                        spr_q      <= sprite;
                        row_q      <= '0;
                        col_q      <= '0;
                        mem_addr_q <= row_addr(sprite, '0);
                        busy_q     <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // ROM samples mem_addr at the end of this cycle.
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    // ROM data is valid now; first pixel of the row goes out next cycle.
                    rowreg_q <= mem_data;
                    col_q    <= '0;
                    colour_q <= mem_data[7];
                    plot_q   <= TRANSPARENT ? mem_data[7] : 1'b1;
                    x_q      <= x0_q;
                    y_q      <= y0_q + 7'(row_q);
                    state_q  <= S_DRAW;
                end
                S_DRAW: begin
                    if (col_q == 3'd7) begin
                        colour_q <= 1'b0;
                        plot_q   <= 1'b0;
                        if (row_q == RW'(ROWS - 1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            row_q      <= row_d;
                            mem_addr_q <= row_addr(spr_q, row_d);
                            state_q    <= S_FETCH;
                        end
                    end else begin
                        col_q    <= col_q + 3'd1;
                        colour_q <= pix_d;
                        plot_q   <= TRANSPARENT ? pix_d : 1'b1;
                        x_q      <= x_d;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: one opaque and one transparent instance share the
// same command inputs, each with its own synchronous ROM model.
module tb_sprite_blitter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [1:0] sprite;

    logic [4:0] a_addr, b_addr;
    logic [7:0] a_rd, b_rd;
    logic [7:0] a_x, b_x;
    logic [6:0] a_y, b_y;
    logic       a_colour, b_colour, a_plot, b_plot, a_busy, b_busy, a_done, b_done;
    logic [2:0] a_state, b_state;

    sprite_blitter #(.ROWS(8), .TRANSPARENT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .sprite(sprite),
        .mem_addr(a_addr), .mem_data(a_rd), .x(a_x), .y(a_y), .colour(a_colour),
        .plot(a_plot), .busy(a_busy), .done(a_done), .state_o(a_state)
    );

    sprite_blitter #(.ROWS(8), .TRANSPARENT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .sprite(sprite),
        .mem_addr(b_addr), .mem_data(b_rd), .x(b_x), .y(b_y), .colour(b_colour),
        .plot(b_plot), .busy(b_busy), .done(b_done), .state_o(b_state)
    );

    // Synchronous ROM: data valid the cycle after the address.
    logic [7:0] rom [32];
    always @(posedge clk) begin
        a_rd <= rom[a_addr];
        b_rd <= rom[b_addr];
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic [1:0] spr;
        int         pop;
    } vec_t;

    vec_t vecs[5];

    // Model of the held pixel coordinates (both instances track the same x/y).
    logic [7:0] ex_last;
    logic [6:0] ey_last;

    // ---------------- driver: one sprite, checked cycle by cycle ----------------
    // abort_at = 0: full run. abort_at = N: reset is sampled at edge k+N.
    task automatic run_sprite(input vec_t v, input int abort_at);
        int         plots_a, plots_b, dones_a, dones_b, r, p, col, last_n;
        logic [7:0] bits;
        logic       ebusy, edone, eplot_a, eplot_b, ecol;
        plots_a = 0; plots_b = 0; dones_a = 0; dones_b = 0;
        @(negedge clk);
        start = 1'b1; x0 = v.x0; y0 = v.y0; sprite = v.spr;
        @(negedge clk);   // cycle k+1
        last_n = (abort_at > 0) ? abort_at + 1 : 82;
        for (int n = 1; n <= last_n; n++) begin
            if (abort_at > 0 && n == abort_at + 1) begin
                check("abort_a", {a_busy, a_done, a_plot, a_colour, a_x, a_y, a_addr, a_state}, 32'd0);
                check("abort_b", {b_busy, b_done, b_plot, b_colour, b_x, b_y, b_addr, b_state}, 32'd0);
                ex_last = '0;
                ey_last = '0;
                reset   = 1'b0;
            end else begin
                r = (n - 1) / 10;
                p = (n - 1) % 10;
                ebusy = 1'b1; edone = 1'b0; eplot_a = 1'b0; eplot_b = 1'b0; ecol = 1'b0;
                if (n == 81) begin
                    edone = 1'b1;
                end else if (n == 82) begin
                    ebusy = 1'b0;
                end else if (p >= 2) begin
                    col     = p - 2;
                    bits    = rom[v.spr * 8 + r];
                    ecol    = bits[7 - col];
                    ex_last = v.x0 + 8'(col);
                    ey_last = v.y0 + 7'(r);
                    eplot_a = 1'b1;
                    eplot_b = ecol;
                end
                check("pixel_a", {a_busy, a_done, a_plot, a_colour, a_x, a_y},
                      {ebusy, edone, eplot_a, ecol, ex_last, ey_last});
                check("pixel_b", {b_busy, b_done, b_plot, b_colour, b_x, b_y},
                      {ebusy, edone, eplot_b, ecol, ex_last, ey_last});
                if (n <= 80 && p < 2) begin
                    check("addr_a", a_addr, 32'(5'(v.spr * 8 + r)));
                    check("addr_b", b_addr, 32'(5'(v.spr * 8 + r)));
                end
                plots_a += int'(a_plot);
                plots_b += int'(b_plot);
                dones_a += int'(a_done);
                dones_b += int'(b_done);
            end
            // Disturb the command inputs; start pulses land while busy (incl. DONE).
            start  = (n == 40 || n == 81) && (n != last_n);
            x0     = 8'($urandom_range(0, 255));
            y0     = 7'($urandom_range(0, 127));
            sprite = 2'($urandom_range(0, 3));
            if (abort_at > 0 && n == abort_at) reset = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        if (abort_at > 0) begin
            check("abort_no_done_a", dones_a, 0);
            check("abort_no_done_b", dones_b, 0);
        end else begin
            check("plot_count_a", plots_a, 64);
            check("plot_count_b", plots_b, v.pop);
            check("done_count_a", dones_a, 1);
            check("done_count_b", dones_b, 1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] s0 [8];
        logic [7:0] s2 [8];
        logic [7:0] s3 [8];
        s0 = '{8'hA5, 8'h3C, 8'h81, 8'h00, 8'hFF, 8'h5A, 8'h0F, 8'hF0};
        s2 = '{8'h01, 8'h80, 8'h11, 8'h22, 8'h44, 8'h88, 8'hC3, 8'h7E};
        s3 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 8; i++) begin
            rom[i]      = s0[i];
            rom[8 + i]  = (i == 0) ? 8'hFF : 8'h00;
            rom[16 + i] = s2[i];
            rom[24 + i] = s3[i];
        end

        // {x0, y0, sprite, hand-counted popcount of that sprite}
        vecs[0] = '{8'd10,  7'd20,  2'd1, 8};
        vecs[1] = '{8'd252, 7'd125, 2'd0, 30};
        vecs[2] = '{8'd0,   7'd0,   2'd2, 20};
        vecs[3] = '{8'd100, 7'd60,  2'd3, 32};
        vecs[4] = '{8'd255, 7'd127, 2'd3, 32};

        ex_last = '0;
        ey_last = '0;
        reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; sprite = '0;
        repeat (3) @(negedge clk);
        check("reset_a", {a_busy, a_done, a_plot, a_colour, a_x, a_y, a_addr, a_state}, 32'd0);
        check("reset_b", {b_busy, b_done, b_plot, b_colour, b_x, b_y, b_addr, b_state}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_sprite(vecs[i], 0);

        // Abort mid-sprite, then a fresh command completes normally.
        run_sprite(vecs[3], 30);
        run_sprite(vecs[2], 0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; x0 = 8'd5; y0 = 7'd5; sprite = 2'd1;
        @(negedge clk);
        check("rst_prio_a", {a_busy, a_state}, 32'd0);
        check("rst_prio_b", {b_busy, b_state}, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_prio_idle_a", {a_busy, a_state}, 32'd0);
        ex_last = '0;
        ey_last = '0;
        run_sprite(vecs[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter ROWS, default 8: sprite height in rows; sprite width is fixed at 8 pixels, one memory word per row.
REQ-002 Parameter TRANSPARENT, default 0: 0 = every pixel plotted; 1 = only pixels whose bit is 1 are plotted.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  command strobe; sampled only in IDLE.
REQ-006 x0  in  8  sprite top-left x.
REQ-007 y0  in  7  sprite top-left y.
REQ-008 sprite  in  2  sprite index.
REQ-009 mem_addr  out  5  sprite memory row address.
REQ-010 mem_data  in  8  sprite memory row data, valid one cycle after mem_addr (synchronous ROM).
REQ-011 x  out  8  pixel x to VGA stage.
REQ-012 y  out  7  pixel y to VGA stage.
REQ-013 colour  out  1  pixel colour (row bit value).
REQ-014 plot  out  1  pixel write enable to VGA stage, one pixel per cycle.
REQ-015 busy  out  1  high from first cycle after start accepted through done cycle.
REQ-016 done  out  1  one-cycle pulse on completion.

Function
REQ-017 The block SHALL implement states IDLE, FETCH, LATCH, DRAW, DONE.
REQ-018 IDLE: start=1 at edge k SHALL capture x0, y0, sprite and enter FETCH in cycle k+1; row=0, col=0.
REQ-019 FETCH SHALL drive mem_addr = sprite*ROWS + row (truncated to 5 bits) for one cycle, then enter LATCH.
REQ-020 LATCH SHALL hold mem_addr and capture mem_data into an 8-bit row register at its end, then enter DRAW.
REQ-021 DRAW SHALL last exactly 8 cycles, col 0..7; colour = rowreg[7-col] (MSB leftmost).
REQ-022 In DRAW, x SHALL equal (x0_cap + col) mod 256 and y SHALL equal (y0_cap + row) mod 128; wrap-around is silent.
REQ-023 In DRAW, plot SHALL be 1 when TRANSPARENT=0, else equal to colour.
REQ-024 After col 7: if row < ROWS-1, row increments and state SHALL return to FETCH; else enter DONE.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 Per row cost SHALL be 10 cycles; with ROWS=8, start accepted at edge k gives plot cycles k+3..k+10, ..., k+73..k+80, done in cycle k+81, IDLE in k+82.
REQ-027 Outside DRAW, plot SHALL be 0 and colour SHALL be 0; x, y hold last values.
REQ-028 busy SHALL be 1 in FETCH, LATCH, DRAW, DONE; 0 in IDLE.
REQ-029 start while busy (including the DONE cycle) SHALL be ignored; no queuing.
REQ-030 Changes on x0, y0, sprite after acceptance SHALL not affect the sprite in progress.
REQ-031 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-032 reset=1 at an edge SHALL force IDLE; busy, done, plot, colour, x, y, mem_addr, row, col, rowreg all 0 in the following cycle.
REQ-033 reset mid-operation SHALL abort without a done pulse; plot SHALL be 0 in the cycle after the reset edge.
REQ-034 reset has priority over start in the same cycle.

Verification
REQ-035 ROM sprite 1 rows = 0xFF,0x00,...; start x0=10,y0=20,sprite=1 at edge k -> mem_addr=8 in k+1; plot k+3..k+10 at x=10..17,y=20,colour=1; done in k+81 only.
REQ-036 TRANSPARENT=1, row0=0xA5 -> plot asserted only at col 0,2,5,7 (x0+0,+2,+5,+7); total plots equal ROM popcount.
REQ-037 x0=252,y0=125,sprite=0 -> x wraps 252,253,254,255,0,1,2,3; rows 3..7 at y=0..4.
REQ-038 start pulsed at k+40 and in DONE cycle -> ignored; exactly 64 plot cycles and one done pulse.
REQ-039 reset asserted at k+30 -> plot=0, busy=0 from k+31; no done; new start at k+33 completes normally.
REQ-040 x0/y0/sprite changed every cycle during operation -> output coordinates match captured values.
